// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the ALU / mux select codes also used by ALU control and the datapath.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_SEXT    = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Dispatch from DECODE; anything unsupported parks the machine in HALT.
  function automatic logic [3:0] decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_next = S_EXEC;
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_J:         decode_next = S_JUMP;
      OP_ADDI:      decode_next = S_ADDIEX;
      default:      decode_next = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Wrapping retired-instruction counter; clear has priority over increment.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: Moore decode of state into datapath controls,
// mem_ready stalls in FETCH/MEMRD/MEMWR, sticky illegal flag, retire count.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       retire_inc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(opcode);
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    retire_inc    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_SEXT_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_inc = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        retire_inc = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire_inc = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire_inc = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire_inc    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        retire_inc = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts the in-flight instruction: no side effects reach the datapath.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clock_i (clock),
    .clear_i (reset),
    .inc_i   (retire_inc),
    .count_o (retired)
  );

  assign illegal_op = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle bench: each cycle pushes the expected control word
// (state, controls, illegal flag, retired count) and compares it to the DUT.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 25;

  logic             clock;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  int           n_pass;
  int           n_total;
  logic [3:0]   exp_ret;
  logic         exp_ill;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .retired       (retired),
    .state_dbg     (state_dbg)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected controls for a state, written from the state table.
  function automatic logic [W-1:0] exp_word(input logic [3:0] st, input logic mr,
                                            input logic rst, input logic ill,
                                            input logic [3:0] ret);
    logic pw, pwc, ia, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb, aop, psrc;
    {pw, pwc, ia, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
    sb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      S_FETCH:  begin mrd = 1'b1; sb = 2'd1; pw = mr; irw = mr; end
      S_DECODE: sb = 2'd3;
      S_MEMADR: begin sa = 1'b1; sb = 2'd2; end
      S_MEMRD:  begin mrd = 1'b1; ia = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; ia = 1'b1; end
      S_EXEC:   begin sa = 1'b1; aop = 2'd2; end
      S_RWB:    begin rw = 1'b1; rdst = 1'b1; end
      S_ADDIEX: begin sa = 1'b1; sb = 2'd2; end
      S_ADDIWB: rw = 1'b1;
      S_BRANCH: begin sa = 1'b1; aop = 2'd1; pwc = 1'b1; psrc = 2'd1; end
      S_JUMP:   begin pw = 1'b1; psrc = 2'd2; end
      default: ;
    endcase
    if (rst) {pw, pwc, mrd, mwr, irw, rw} = '0;
    return {st, pw, pwc, ia, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc, ill, ret};
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom_range(0, 63));
  endfunction

  // Driver + scoreboard: one call per clock cycle.
  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic mr,
                     input logic rst, input logic fin, input string tag);
    logic [W-1:0] obs, e;
    @(negedge clock);
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(exp_word(st, mr, rst, exp_ill, exp_ret));
    #1;
    obs = {state_dbg, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op, retired};
    e = exp_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    if (rst) begin
      exp_ret = '0;
      exp_ill = 1'b0;
    end else if (fin) begin
      exp_ret = exp_ret + 4'd1;
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_ret   = '0;
    exp_ill   = 1'b0;
    reset     = 1'b1;
    opcode    = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);

    // Reset holds FETCH with every enable forced low.
    cyc(S_FETCH, junk(), 1'b1, 1'b1, 1'b0, "reset_fetch");

    // addi
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "addi_fetch");
    cyc(S_DECODE, OP_ADDI, 1'b1, 1'b0, 1'b0, "addi_decode");
    cyc(S_ADDIEX, junk(), 1'b1, 1'b0, 1'b0, "addi_ex");
    cyc(S_ADDIWB, junk(), 1'b1, 1'b0, 1'b1, "addi_wb");

    // lw with two stall cycles in MEMRD; opcode bus shows sw during MEMADR
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "lw_fetch");
    cyc(S_DECODE, OP_LW, 1'b1, 1'b0, 1'b0, "lw_decode");
    cyc(S_MEMADR, OP_SW, 1'b1, 1'b0, 1'b0, "lw_memadr");
    cyc(S_MEMRD,  junk(), 1'b0, 1'b0, 1'b0, "lw_memrd_stall0");
    cyc(S_MEMRD,  junk(), 1'b0, 1'b0, 1'b0, "lw_memrd_stall1");
    cyc(S_MEMRD,  junk(), 1'b1, 1'b0, 1'b0, "lw_memrd");
    cyc(S_MEMWB,  junk(), 1'b1, 1'b0, 1'b1, "lw_memwb");

    // sw (one write stall), beq, j back-to-back
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "sw_fetch");
    cyc(S_DECODE, OP_SW, 1'b1, 1'b0, 1'b0, "sw_decode");
    cyc(S_MEMADR, OP_LW, 1'b1, 1'b0, 1'b0, "sw_memadr");
    cyc(S_MEMWR,  junk(), 1'b0, 1'b0, 1'b0, "sw_memwr_stall");
    cyc(S_MEMWR,  junk(), 1'b1, 1'b0, 1'b1, "sw_memwr");
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "beq_fetch");
    cyc(S_DECODE, OP_BEQ, 1'b1, 1'b0, 1'b0, "beq_decode");
    cyc(S_BRANCH, junk(), 1'b1, 1'b0, 1'b1, "beq_branch");
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "j_fetch");
    cyc(S_DECODE, OP_J, 1'b1, 1'b0, 1'b0, "j_decode");
    cyc(S_JUMP,   junk(), 1'b1, 1'b0, 1'b1, "j_jump");

    // R-type with a fetch stall
    cyc(S_FETCH,  junk(), 1'b0, 1'b0, 1'b0, "r_fetch_stall");
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "r_fetch");
    cyc(S_DECODE, OP_RTYPE, 1'b1, 1'b0, 1'b0, "r_decode");
    cyc(S_EXEC,   junk(), 1'b1, 1'b0, 1'b0, "r_exec");
    cyc(S_RWB,    junk(), 1'b1, 1'b0, 1'b1, "r_rwb");

    // Reset during MEMRD aborts the load
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "abort_fetch");
    cyc(S_DECODE, OP_LW, 1'b1, 1'b0, 1'b0, "abort_decode");
    cyc(S_MEMADR, junk(), 1'b1, 1'b0, 1'b0, "abort_memadr");
    cyc(S_MEMRD,  junk(), 1'b1, 1'b1, 1'b0, "abort_memrd_reset");
    cyc(S_FETCH,  junk(), 1'b0, 1'b0, 1'b0, "abort_after");

    // 16 jumps: the 4-bit counter climbs to 15 and wraps to 0
    for (int i = 0; i < 16; i++) begin
      cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "wrap_fetch");
      cyc(S_DECODE, OP_J, 1'b1, 1'b0, 1'b0, "wrap_decode");
      cyc(S_JUMP,   junk(), 1'b1, 1'b0, 1'b1, "wrap_jump");
    end

    // Illegal opcode: HALT, sticky flag, nothing enabled until reset
    cyc(S_FETCH,  junk(), 1'b1, 1'b0, 1'b0, "ill_fetch");
    cyc(S_DECODE, 6'b111111, 1'b1, 1'b0, 1'b0, "ill_decode");
    exp_ill = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc(S_HALT, junk(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, "ill_halt");
    cyc(S_HALT,  junk(), 1'b1, 1'b1, 1'b0, "ill_reset");
    cyc(S_FETCH, junk(), 1'b1, 1'b0, 1'b0, "ill_after_reset");
    cyc(S_DECODE, OP_ADDI, 1'b1, 1'b0, 1'b0, "ill_recover_decode");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath: the register file, sign extender, ALU, shared instruction/data memory and PC. It takes the opcode produced by decode and steps each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select as a Moore function of its state. It stalls on a memory ready handshake and counts retired instructions.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- opcode  in  6  instruction[31:26] from decode; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address source: 0 = PC, 1 = ALU out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data source: 1 = memory data
- reg_dst  out  1  write-back register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = signex, 3 = signex<<2
- alu_op  out  2  0 = add, 1 = sub, 2 = use funct
- pc_source  out  2  0 = ALU result, 1 = ALU out register, 2 = jump target
- illegal_op  out  1  sticky; unsupported opcode seen
- retired  out  CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

## Operation

States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.

- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1; the state then moves to DECODE.
  - If mem_ready=0, the state holds in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other opcode → HALT
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next state is MEMRD for lw, MEMWR for sw, using the opcode latched in DECODE.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=2. Next state FETCH.
- HALT: all enables 0; illegal_op=1. The state stays in HALT until reset.
- Outputs not listed for a state are 0.
- retired increments by 1 in the final cycle of each instruction: MEMWB, MEMWR with mem_ready=1, RWB, ADDIWB, BRANCH, JUMP. It wraps modulo 2^CNT_W and never saturates.

## Timing

- Reset: on a clock edge with reset=1, the state becomes FETCH, retired becomes 0 and illegal_op becomes 0.
  - While reset=1, all enable outputs (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced to 0.
  - Reset mid-instruction aborts the instruction: no write is issued and the counter is not incremented.
- All control outputs are combinational decode of the registered state, plus mem_ready gating in FETCH and MEMWR.
- The opcode is sampled on the edge that leaves DECODE. It is held in an internal register for MEMADR.
- Latency in cycles with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_read and mem_write are never asserted together.

## Structure

- Shared package holds the state enum (4-bit encoding, FETCH=0, HALT=12), the opcode constants, and the alu_op, alu_src_b and pc_source encodings. These are shared with the ALU control and datapath blocks.
- Sub-module `retire_counter` holds the CNT_W-bit counter with increment and synchronous clear. Everything else is one FSM module with a next-state block and an output block.

## Test plan

- Reset then addi (opcode 001000), mem_ready=1 → states FETCH, DECODE, ADDIEX, ADDIWB; reg_write=1 only in cycle 4; retired=1.
- lw with mem_ready low for 2 cycles in MEMRD → 7 cycles total; mem_to_reg=1 and reg_write=1 in MEMWB only; iord=1 in MEMRD.
- sw, then beq, then j back-to-back → 4+3+3 cycles; pc_write_cond=1 only in BRANCH; pc_source=2 and pc_write=1 in JUMP; retired=3.
- Opcode 111111 → HALT after DECODE; illegal_op=1 and stays 1; no enables for 10 cycles; a reset pulse returns to FETCH with illegal_op=0.
- Reset asserted during MEMRD → next state FETCH; retired=0; reg_write never pulses.
- Preload retired near 2^CNT_W−1 (CNT_W=4, 16 j instructions) → counter wraps to 0.
